screen_fader: RTL and testbench
===============================

// Module: screen_fader
// PURPOSE
//   Final colour stage between the palette lookup and the VGA DAC pins.
//   - Takes the 24-bit palette colour and display-enable, scales each channel by a global fade level, blanks outside the active area, and drives 4-bit R/G/B.
//   - Runs the fade-to-black / fade-from-black sequence used for battle and map transitions.
//   - The fade level changes only on frame boundaries, so no frame ever shows two different levels.
// PARAMETERS
//   STEPS            16  fade levels; level range 0..STEPS, where STEPS = full brightness; power of two
//   FRAMES_PER_STEP  2   frame_start pulses between level changes; >=1
// PORTS
//   Clk           in   1   pixel clock
//   Reset_n       in   1   asynchronous, active-low reset
//   pixel_color   in   24  {R,G,B} 8b each, from palette stage
//   display_en    in   1   1 = active video pixel
//   frame_start   in   1   1-cycle pulse at start of vertical blank
//   fade_out_req  in   1   1-cycle pulse: start fading to black
//   fade_in_req   in   1   1-cycle pulse: start fading to full
//   red           out  4   VGA red
//   green         out  4   VGA green
//   blue          out  4   VGA blue
//   busy          out  1   1 while FADING_OUT or FADING_IN
//   dark          out  1   1 while in DARK
//   fade_done     out  1   1-cycle pulse when DARK or SHOWN is entered from a fade
// BEHAVIOUR
//   Reset (async, Reset_n=0):
//   - state=SHOWN, level=STEPS, frame_cnt=0.
//   - Pipeline registers and red/green/blue = 0; busy=dark=fade_done=0.
//   - Reset mid-fade abandons the fade immediately.
//   FSM states: SHOWN, FADING_OUT, DARK, FADING_IN.
//   - SHOWN      + fade_out_req -> FADING_OUT, frame_cnt=0.
//   - FADING_OUT + fade_in_req  -> FADING_IN, frame_cnt=0, level held (reversal).
//   - FADING_IN  + fade_out_req -> FADING_OUT, frame_cnt=0, level held (reversal).
//   - DARK       + fade_in_req  -> FADING_IN, frame_cnt=0.
//   - Requests are ignored in every other state: fade_out_req in FADING_OUT or DARK, fade_in_req in FADING_IN or SHOWN.
//   - fade_out_req and fade_in_req high in the same cycle: both ignored.
//   Stepping while fading, on each frame_start:
//   - frame_cnt < FRAMES_PER_STEP-1: frame_cnt+1.
//   - Otherwise: frame_cnt=0 and level -1 (FADING_OUT) or +1 (FADING_IN).
//   - Level reaches 0: state=DARK. Level reaches STEPS: state=SHOWN.
//   - fade_done is registered and asserts the cycle after the entering frame_start.
//   - A request and a frame_start in the same cycle: the request wins; no step that cycle.
//   - frame_start outside the fading states has no effect.
//   Datapath (latency 2, all registered):
//   - S1: register pixel_color, display_en and the current level.
//   - S2: per channel, prod = c8 * lvl (13b unsigned); scaled = prod >> log2(STEPS); result clamped to 255.
//   - Output: red/green/blue = scaled[7:4] if display_en_d2, else 0.
//   - Inputs sampled at cycle N drive the outputs at N+2. display_en passes through the same 2-stage delay.
//   Status outputs:
//   - busy = state in {FADING_OUT, FADING_IN}; dark = (state==DARK); both are registered.
// TESTING
//   1. Reset, then pixel_color=FFFFFF, display_en=1 -> at N+2 red/green/blue=F/F/F; busy=0, dark=0.
//   2. display_en=0 with pixel_color=FFFFFF -> outputs 0/0/0 at N+2; 2-cycle alignment holds across a 0->1->0 enable toggle.
//   3. fade_out_req, then 32 frame_starts, pixel_color=F8D0B8 -> after 16 frame_starts (level 8):
//      R=7, G=6, B=5 (7C,68,5C >>4). After 32: dark=1, a single fade_done pulse, outputs 0/0/0.
//   4. From DARK, fade_in_req, then 32 frame_starts -> level back at 16, state SHOWN, fade_done once, busy=0; FFFFFF -> F/F/F.
//   5. Reversal: fade_out_req, 10 frame_starts (level 11), fade_in_req -> busy stays 1; level reaches 16 after 10 more frame_starts.
//      Same cycle as both requests: no change. Request coinciding with frame_start: level is not stepped that cycle.
//   6. Drop Reset_n mid-FADING_OUT (level 5) -> outputs 0 immediately; after release state=SHOWN, level=16, busy=0, dark=0.

Source files
------------

// File: rtl/screen_fader_if.sv
// Pixel, fade-control and VGA-side signals of the final colour stage, grouped as one bus.
// The master drives colour/enable/requests; the slave drives the DAC nibbles and status.
interface screen_fader_if;
    logic [23:0] pixel_color;
    logic        display_en;
    logic        frame_start;
    logic        fade_out_req;
    logic        fade_in_req;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        busy;
    logic        dark;
    logic        fade_done;

    modport master (
        output pixel_color, display_en, frame_start, fade_out_req, fade_in_req,
        input  red, green, blue, busy, dark, fade_done
    );

    modport slave (
        input  pixel_color, display_en, frame_start, fade_out_req, fade_in_req,
        output red, green, blue, busy, dark, fade_done
    );
endinterface

// File: rtl/screen_fader.sv
// Final colour stage: scales palette colour by a frame-synchronous fade level and
// drives 4-bit VGA channels, plus the fade-to/from-black sequencer.
module screen_fader #(
    parameter int STEPS           = 16,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    screen_fader_if.slave bus
);
    localparam int LW    = $clog2(STEPS + 1);
    localparam int SHIFT = $clog2(STEPS);
    localparam int CW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int PW    = 8 + LW;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(STEPS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        SHOWN      = 2'd0,
        FADING_OUT = 2'd1,
        DARK       = 2'd2,
        FADING_IN  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [LW-1:0]   level_reg;
    logic [CW-1:0]   frame_cnt_reg;
    logic            busy_reg;
    logic            dark_reg;
    logic            fade_done_reg;

    // Simultaneous requests cancel each other out.
    logic out_req;
    logic in_req;
    assign out_req = bus.fade_out_req & ~bus.fade_in_req;
    assign in_req  = bus.fade_in_req & ~bus.fade_out_req;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= SHOWN;
            level_reg     <= LEVEL_MAX;
            frame_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            dark_reg      <= 1'b0;
            fade_done_reg <= 1'b0;
        end else begin
            fade_done_reg <= 1'b0;
            case (state_reg)
                SHOWN: begin
                    if (out_req) begin
                        state_reg     <= FADING_OUT;
                        frame_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        dark_reg      <= 1'b0;
                    end
                end
                FADING_OUT: begin
                    if (in_req) begin
                        state_reg     <= FADING_IN;
                        frame_cnt_reg <= '0;
                    end else if (bus.frame_start) begin
                        if (frame_cnt_reg < CNT_LAST) begin
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end else begin
                            frame_cnt_reg <= '0;
                            if (level_reg < LW'(2)) begin
                                level_reg     <= '0;
                                state_reg     <= DARK;
                                busy_reg      <= 1'b0;
                                dark_reg      <= 1'b1;
                                fade_done_reg <= 1'b1;
                            end else begin
                                level_reg <= level_reg - 1'b1;
                            end
                        end
                    end
                end
                DARK: begin
                    if (in_req) begin
                        state_reg     <= FADING_IN;
                        frame_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        dark_reg      <= 1'b0;
                    end
                end
                FADING_IN: begin
                    if (out_req) begin
                        state_reg     <= FADING_OUT;
                        frame_cnt_reg <= '0;
                    end else if (bus.frame_start) begin
                        if (frame_cnt_reg < CNT_LAST) begin
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end else begin
                            frame_cnt_reg <= '0;
                            if (level_reg >= LEVEL_MAX - LW'(1)) begin
                                level_reg     <= LEVEL_MAX;
                                state_reg     <= SHOWN;
                                busy_reg      <= 1'b0;
                                dark_reg      <= 1'b0;
                                fade_done_reg <= 1'b1;
                            end else begin
                                level_reg <= level_reg + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg     <= SHOWN;
                    level_reg     <= LEVEL_MAX;
                    frame_cnt_reg <= '0;
                    busy_reg      <= 1'b0;
                    dark_reg      <= 1'b0;
                end
            endcase
        end
    end

    // Level is captured alongside the pixel so a mid-frame level update cannot split a pixel.
    logic [23:0]   pixel_d1_reg;
    logic          display_en_d1_reg;
    logic [LW-1:0] level_d1_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_d1_reg      <= '0;
            display_en_d1_reg <= 1'b0;
            level_d1_reg      <= '0;
        end else begin
            pixel_d1_reg      <= bus.pixel_color;
            display_en_d1_reg <= bus.display_en;
            level_d1_reg      <= level_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_ch
            logic [7:0]    c8;
            logic [PW-1:0] prod;
            logic [PW-1:0] scaled;
            logic [3:0]    nib;
            logic [3:0]    chan_reg;

            assign c8     = pixel_d1_reg[23-8*gi -: 8];
            assign prod   = PW'(c8) * PW'(level_d1_reg);
            assign scaled = prod >> SHIFT;
            assign nib    = (scaled > PW'(255)) ? 4'hF : scaled[7:4];

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    chan_reg <= 4'h0;
                end else begin
                    chan_reg <= display_en_d1_reg ? nib : 4'h0;
                end
            end
        end
    endgenerate

    assign bus.red       = gen_ch[0].chan_reg;
    assign bus.green     = gen_ch[1].chan_reg;
    assign bus.blue      = gen_ch[2].chan_reg;
    assign bus.busy      = busy_reg;
    assign bus.dark      = dark_reg;
    assign bus.fade_done = fade_done_reg;
endmodule

// File: tb/tb_screen_fader.sv
// Directed bench for screen_fader: a behavioural fade/pixel model checked every cycle,
// plus hand-computed literal expectations at the interesting points of each scenario.
module tb_screen_fader;
    localparam int STEPS = 16;
    localparam int FPS   = 2;

    localparam int M_SHOWN = 0;
    localparam int M_OUT   = 1;
    localparam int M_DARK  = 2;
    localparam int M_IN    = 3;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    screen_fader_if bus ();

    screen_fader #(.STEPS(STEPS), .FRAMES_PER_STEP(FPS)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int done_count = 0;

    // Model state
    int          m_state = M_SHOWN;
    int          m_level = STEPS;
    int          m_cnt   = 0;
    logic [11:0] m_pipe  = 12'h000;
    logic [11:0] m_out   = 12'h000;
    logic        m_done  = 1'b0;

    function automatic logic [3:0] chan(input int c, input int lvl);
        int v;
        v = (c * lvl) / STEPS;
        if (v > 255) v = 255;
        return 4'(v / 16);
    endfunction

    function automatic logic [11:0] expect_rgb(input logic [23:0] px, input logic en, input int lvl);
        int r, g, b;
        if (!en) return 12'h000;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        return {chan(r, lvl), chan(g, lvl), chan(b, lvl)};
    endfunction

    // Behavioural model: pixel expectation travels two edges; fade steps by frame count.
    initial begin
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) begin
                m_state = M_SHOWN;
                m_level = STEPS;
                m_cnt   = 0;
                m_pipe  = 12'h000;
                m_out   = 12'h000;
                m_done  = 1'b0;
            end else begin
                logic o_r, i_r;
                m_out  = m_pipe;
                m_pipe = expect_rgb(bus.pixel_color, bus.display_en, m_level);
                m_done = 1'b0;
                o_r = bus.fade_out_req && !bus.fade_in_req;
                i_r = bus.fade_in_req && !bus.fade_out_req;
                if (o_r && (m_state == M_SHOWN || m_state == M_IN)) begin
                    m_state = M_OUT;
                    m_cnt   = 0;
                end else if (i_r && (m_state == M_DARK || m_state == M_OUT)) begin
                    m_state = M_IN;
                    m_cnt   = 0;
                end else if (bus.frame_start && (m_state == M_OUT || m_state == M_IN)) begin
                    if (m_cnt < FPS - 1) begin
                        m_cnt = m_cnt + 1;
                    end else begin
                        m_cnt = 0;
                        if (m_state == M_OUT) begin
                            m_level = (m_level > 0) ? m_level - 1 : 0;
                            if (m_level == 0) begin
                                m_state = M_DARK;
                                m_done  = 1'b1;
                            end
                        end else begin
                            m_level = (m_level < STEPS) ? m_level + 1 : STEPS;
                            if (m_level == STEPS) begin
                                m_state = M_SHOWN;
                                m_done  = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge Clk);
            n_checks++;
            if ({bus.red, bus.green, bus.blue} !== m_out) begin
                n_errors++;
                $display("FAIL cyc_rgb @%0t: got %h expected %h", $time, {bus.red, bus.green, bus.blue}, m_out);
            end
            n_checks++;
            if ({bus.busy, bus.dark, bus.fade_done} !==
                {(m_state == M_OUT || m_state == M_IN), (m_state == M_DARK), m_done}) begin
                n_errors++;
                $display("FAIL cyc_status @%0t: got busy/dark/done %b%b%b expected %b%b%b", $time,
                         bus.busy, bus.dark, bus.fade_done,
                         (m_state == M_OUT || m_state == M_IN), (m_state == M_DARK), m_done);
            end
            if (bus.fade_done === 1'b1) done_count++;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end else begin
            $display("ok   %s = %0h", name, actual);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        tick(3);
    endtask

    task automatic req(input logic o, input logic i, input logic fs);
        bus.fade_out_req = o;
        bus.fade_in_req  = i;
        bus.frame_start  = fs;
        tick(1);
        bus.fade_out_req = 1'b0;
        bus.fade_in_req  = 1'b0;
        bus.frame_start  = 1'b0;
        tick(2);
    endtask

    logic [23:0] px_tab [5] = '{24'h123456, 24'h89ABCD, 24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0};
    logic        en_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        bus.pixel_color  = 24'h0;
        bus.display_en   = 1'b0;
        bus.frame_start  = 1'b0;
        bus.fade_out_req = 1'b0;
        bus.fade_in_req  = 1'b0;
        tick(3);
        check("reset_rgb", int'({bus.red, bus.green, bus.blue}), 'h000);
        check("reset_status", int'({bus.busy, bus.dark, bus.fade_done}), 0);
        Reset_n = 1'b1;

        // Full brightness pass-through, 2-cycle latency
        bus.pixel_color = 24'hFFFFFF;
        bus.display_en  = 1'b1;
        tick(2);
        check("full_white", int'({bus.red, bus.green, bus.blue}), 'hFFF);

        // Blanking and enable alignment
        bus.display_en = 1'b0;
        tick(2);
        check("blanked", int'({bus.red, bus.green, bus.blue}), 'h000);
        for (int k = 0; k < 5; k++) begin
            bus.pixel_color = px_tab[k];
            bus.display_en  = en_tab[k];
            tick(1);
        end
        tick(2);
        check("toggle_end_rgb", int'({bus.red, bus.green, bus.blue}), 'h000);

        // Fade to black
        bus.pixel_color = 24'hF8D0B8;
        bus.display_en  = 1'b1;
        done_count = 0;
        req(1'b1, 1'b0, 1'b0);
        check("fade_out_busy", int'(bus.busy), 1);
        repeat (16) frame();
        check("model_level_half", m_level, 8);
        check("half_rgb", int'({bus.red, bus.green, bus.blue}), 'h765);
        repeat (16) frame();
        check("dark_flag", int'(bus.dark), 1);
        check("dark_done_count", done_count, 1);
        check("dark_rgb", int'({bus.red, bus.green, bus.blue}), 'h000);
        check("model_level_dark", m_level, 0);

        // Fade back in
        done_count = 0;
        req(1'b0, 1'b1, 1'b0);
        repeat (32) frame();
        bus.pixel_color = 24'hFFFFFF;
        tick(2);
        check("shown_rgb", int'({bus.red, bus.green, bus.blue}), 'hFFF);
        check("shown_status", int'({bus.busy, bus.dark}), 0);
        check("shown_done_count", done_count, 1);
        check("model_level_full", m_level, 16);

        // Reversal; first request coincides with frame_start
        req(1'b1, 1'b0, 1'b1);
        repeat (10) frame();
        check("model_level_rev", m_level, 11);
        check("rev_rgb", int'({bus.red, bus.green, bus.blue}), 'hAAA);
        req(1'b1, 1'b1, 1'b0);
        check("both_req_busy", int'(bus.busy), 1);
        check("model_level_both", m_level, 11);
        done_count = 0;
        req(1'b0, 1'b1, 1'b0);
        check("reversed_busy", int'(bus.busy), 1);
        repeat (10) frame();
        check("rev_end_busy", int'(bus.busy), 0);
        check("rev_end_done_count", done_count, 1);
        check("rev_end_rgb", int'({bus.red, bus.green, bus.blue}), 'hFFF);

        // Reset in the middle of a fade-out
        req(1'b1, 1'b0, 1'b0);
        repeat (22) frame();
        check("model_level_mid", m_level, 5);
        check("mid_rgb", int'({bus.red, bus.green, bus.blue}), 'h444);
        Reset_n = 1'b0;
        #1;
        check("async_rst_rgb", int'({bus.red, bus.green, bus.blue}), 'h000);
        check("async_rst_busy", int'(bus.busy), 0);
        tick(2);
        Reset_n = 1'b1;
        tick(1);
        check("post_rst_status", int'({bus.busy, bus.dark}), 0);
        tick(2);
        check("post_rst_rgb", int'({bus.red, bus.green, bus.blue}), 'hFFF);
        check("model_level_post_rst", m_level, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
